// File: rtl/br_redirect_ctrl.sv
// Execute-stage branch redirect controller: flush, held fetch redirect,
// predictor update pulse and saturating mispredict counter.
module br_redirect_ctrl #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_val,
  input  logic             br_val,
  input  logic             br_taken,
  input  logic             br_correct,
  input  logic [31:0]      br_target,
  input  logic [31:0]      br_fallthru,
  input  logic [31:0]      br_pc,
  input  logic             fetch_rdy,
  output logic             flush,
  output logic             ex_stall,
  output logic             redir_val,
  output logic [31:0]      redir_ip,
  output logic [31:0]      redir_ip_p1,
  output logic             upd_val,
  output logic             upd_taken,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIR = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        res_ev;
  logic        mispred;
  logic [31:0] ip_sel;
  logic        flush_d;
  logic        stall_d;
  logic        redir_val_d;

  // Resolutions are only looked at while no redirect is in flight.
  assign res_ev  = ex_val & br_val & (state == IDLE);
  assign mispred = res_ev & ~br_correct;
  assign ip_sel  = br_taken ? br_target : br_fallthru;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispred) state_nxt = FLUSH;
      FLUSH:   state_nxt = REDIR;
      REDIR:   if (redir_val & fetch_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    flush_d     = 1'b0;
    stall_d     = 1'b0;
    redir_val_d = 1'b0;
    case (state_nxt)
      FLUSH: begin
        flush_d = 1'b1;
        stall_d = 1'b1;
      end
      REDIR: begin
        stall_d     = 1'b1;
        redir_val_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush       <= 1'b0;
      ex_stall    <= 1'b0;
      redir_val   <= 1'b0;
      redir_ip    <= 32'd0;
      redir_ip_p1 <= 32'd0;
      upd_val     <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= 32'd0;
      upd_target  <= 32'd0;
      mispred_cnt <= '0;
    end else begin
      flush     <= flush_d;
      ex_stall  <= stall_d;
      redir_val <= redir_val_d;
      upd_val   <= res_ev;
      if (mispred) begin
        redir_ip    <= ip_sel;
        redir_ip_p1 <= ip_sel + 32'(LINE_BYTES);
      end
      if (res_ev) begin
        upd_taken  <= br_taken;
        upd_pc     <= br_pc;
        upd_target <= br_target;
      end
      if (mispred && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed bench for br_redirect_ctrl: per-cycle scoreboard of a spec-level model
// plus point checks from the test plan; a narrow-counter instance covers saturation.
module tb_br_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset, ex_val, br_val, br_taken, br_correct, fetch_rdy;
  logic [31:0] br_target, br_fallthru, br_pc;

  logic        flush, ex_stall, redir_val, upd_val, upd_taken;
  logic [31:0] redir_ip, redir_ip_p1, upd_pc, upd_target;
  logic [15:0] mispred_cnt;

  logic        s_flush, s_ex_stall, s_redir_val, s_upd_val, s_upd_taken;
  logic [31:0] s_redir_ip, s_redir_ip_p1, s_upd_pc, s_upd_target;
  logic [3:0]  s_mispred_cnt;

  always #5 clk = ~clk;

  br_redirect_ctrl dut (
    .clk(clk), .reset(reset), .ex_val(ex_val), .br_val(br_val), .br_taken(br_taken),
    .br_correct(br_correct), .br_target(br_target), .br_fallthru(br_fallthru), .br_pc(br_pc),
    .fetch_rdy(fetch_rdy), .flush(flush), .ex_stall(ex_stall), .redir_val(redir_val),
    .redir_ip(redir_ip), .redir_ip_p1(redir_ip_p1), .upd_val(upd_val), .upd_taken(upd_taken),
    .upd_pc(upd_pc), .upd_target(upd_target), .mispred_cnt(mispred_cnt));

  // Same stimulus, 4-bit counter, so saturation is reachable in a short run.
  br_redirect_ctrl #(.LINE_BYTES(16), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .ex_val(ex_val), .br_val(br_val), .br_taken(br_taken),
    .br_correct(br_correct), .br_target(br_target), .br_fallthru(br_fallthru), .br_pc(br_pc),
    .fetch_rdy(fetch_rdy), .flush(s_flush), .ex_stall(s_ex_stall), .redir_val(s_redir_val),
    .redir_ip(s_redir_ip), .redir_ip_p1(s_redir_ip_p1), .upd_val(s_upd_val),
    .upd_taken(s_upd_taken), .upd_pc(s_upd_pc), .upd_target(s_upd_target),
    .mispred_cnt(s_mispred_cnt));

  int n_tot  = 0;
  int n_pass = 0;
  string step = "init";

  logic [148:0] exp_q[$];
  logic [148:0] exp_qs[$];

  logic [1:0]  m_st;
  logic [31:0] m_ip, m_ip1, m_upc, m_utgt;
  logic        m_uv, m_ut;
  int          m_cnt, m_cnt_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk_vec(input string tag, input logic [148:0] got, input logic [148:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%038h expected 0x%038h", tag, got, exp);
  endtask

  task automatic set_in(input logic exv, input logic brv, input logic tk, input logic cor,
                        input logic [31:0] tgt, input logic [31:0] ft, input logic [31:0] pc,
                        input logic rdy);
    ex_val = exv; br_val = brv; br_taken = tk; br_correct = cor;
    br_target = tgt; br_fallthru = ft; br_pc = pc; fetch_rdy = rdy;
  endtask

  task automatic idle_in(input logic rdy);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, rdy);
  endtask

  // Advance one clock: model predicts post-edge outputs, scoreboard compares both DUTs.
  task automatic cycle();
    logic [148:0] e, es, g, gs;
    logic ev;
    ev = ex_val & br_val & (m_st == 2'd0);
    if (reset) begin
      m_st = 2'd0; m_ip = 0; m_ip1 = 0; m_uv = 0; m_ut = 0; m_upc = 0; m_utgt = 0;
      m_cnt = 0; m_cnt_s = 0;
    end else begin
      case (m_st)
        2'd0: if (ev && !br_correct) begin
          m_st  = 2'd1;
          m_ip  = br_taken ? br_target : br_fallthru;
          m_ip1 = m_ip + 32'd16;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 15) m_cnt_s++;
        end
        2'd1: m_st = 2'd2;
        2'd2: if (fetch_rdy) m_st = 2'd0;
        default: m_st = 2'd0;
      endcase
      m_uv = ev;
      if (ev) begin m_ut = br_taken; m_upc = br_pc; m_utgt = br_target; end
    end
    e  = {m_st == 2'd1, m_st != 2'd0, m_st == 2'd2, m_ip, m_ip1, m_uv, m_ut, m_upc, m_utgt,
          16'(m_cnt)};
    es = {m_st == 2'd1, m_st != 2'd0, m_st == 2'd2, m_ip, m_ip1, m_uv, m_ut, m_upc, m_utgt,
          16'(m_cnt_s)};
    exp_q.push_back(e);
    exp_qs.push_back(es);
    @(posedge clk);
    #1;
    g  = {flush, ex_stall, redir_val, redir_ip, redir_ip_p1, upd_val, upd_taken, upd_pc,
          upd_target, mispred_cnt};
    gs = {s_flush, s_ex_stall, s_redir_val, s_redir_ip, s_redir_ip_p1, s_upd_val,
          s_upd_taken, s_upd_pc, s_upd_target, 12'd0, s_mispred_cnt};
    chk_vec({step, "_sb"}, g, exp_q.pop_front());
    chk_vec({step, "_sb_narrow"}, gs, exp_qs.pop_front());
  endtask

  initial begin
    int held, pulses;
    m_st = 2'd0;
    reset = 1'b1;
    idle_in(1'b0);
    #2;
    step = "reset";
    cycle(); cycle();
    chk("reset_cnt", 32'(mispred_cnt), 32'd0);
    chk("reset_redir_val", 32'(redir_val), 32'd0);
    reset = 1'b0;
    cycle();

    step = "correct";
    set_in(1, 1, 1, 1, 32'h1200, 32'h1104, 32'h1100, 0);
    cycle();
    chk("correct_upd_val", 32'(upd_val), 32'd1);
    chk("correct_upd_target", upd_target, 32'h1200);
    chk("correct_no_stall", 32'({flush, ex_stall, redir_val}), 32'd0);
    idle_in(1'b0);
    cycle();
    chk("correct_upd_drop", 32'(upd_val), 32'd0);
    chk("correct_upd_hold", upd_pc, 32'h1100);

    step = "taken_rdy";
    set_in(1, 1, 1, 0, 32'h4000, 32'h3004, 32'h3000, 1);
    cycle();
    chk("taken_flush", 32'({flush, ex_stall, redir_val, upd_val}), 32'b1101);
    idle_in(1'b1);
    cycle();
    chk("taken_redir", 32'({flush, ex_stall, redir_val}), 32'b011);
    chk("taken_ip", redir_ip, 32'h4000);
    chk("taken_ip_p1", redir_ip_p1, 32'h4010);
    cycle();
    chk("taken_idle", 32'({ex_stall, redir_val}), 32'd0);
    chk("taken_cnt", 32'(mispred_cnt), 32'd1);

    step = "nt_busy";
    set_in(1, 1, 0, 0, 32'h5000, 32'h2008, 32'h2004, 1);
    cycle();
    held = 0;
    for (int i = 0; i < 5; i++) begin
      idle_in((i == 0 || i == 4) ? 1'b1 : 1'b0);
      cycle();
      if (redir_val && ex_stall && redir_ip == 32'h2008) held++;
    end
    chk("nt_held_cycles", 32'(held), 32'd4);
    chk("nt_released", 32'({ex_stall, redir_val}), 32'd0);

    step = "busy_wrap";
    pulses = 0;
    set_in(1, 1, 1, 0, 32'hFFFF_FFF8, 32'h10, 32'h0C, 0);
    cycle();
    pulses += 32'(upd_val);
    set_in(1, 1, 1, 0, 32'h7777_0000, 32'h20, 32'h1C, 0);
    cycle();
    pulses += 32'(upd_val);
    chk("wrap_ip_p1", redir_ip_p1, 32'h0000_0008);
    chk("wrap_ip", redir_ip, 32'hFFFF_FFF8);
    set_in(1, 1, 0, 0, 32'h8888_0000, 32'h30, 32'h2C, 0);
    cycle();
    pulses += 32'(upd_val);
    set_in(1, 1, 0, 0, 32'h9999_0000, 32'h40, 32'h3C, 1);
    cycle();
    pulses += 32'(upd_val);
    chk("wrap_pulses", 32'(pulses), 32'd1);
    chk("wrap_cnt", 32'(mispred_cnt), 32'd3);
    idle_in(1'b0);
    cycle();

    step = "reset_mid";
    set_in(1, 1, 1, 0, 32'hA000, 32'h50, 32'h4C, 0);
    cycle();
    idle_in(1'b0);
    cycle();
    chk("mid_redir_up", 32'(redir_val), 32'd1);
    reset = 1'b1;
    cycle();
    chk("mid_all_zero", 32'({flush, ex_stall, redir_val, upd_val, upd_taken}), 32'd0);
    chk("mid_data_zero", redir_ip | redir_ip_p1 | upd_pc | upd_target, 32'd0);
    chk("mid_cnt_zero", 32'(mispred_cnt), 32'd0);
    reset = 1'b0;
    held = 0;
    for (int i = 0; i < 4; i++) begin
      idle_in(i[0]);
      cycle();
      if (redir_val || ex_stall) held++;
    end
    chk("mid_no_reissue", 32'(held), 32'd0);

    step = "saturate";
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, i[0], 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 1);
      cycle();
      idle_in(1'b1);
      cycle();
      cycle();
    end
    chk("sat_narrow", 32'(s_mispred_cnt), 32'd15);
    chk("sat_wide", 32'(mispred_cnt), 32'd20);
    set_in(1, 1, 1, 0, 32'h600, 32'h604, 32'h5FC, 1);
    cycle();
    chk("sat_narrow_hold", 32'(s_mispred_cnt), 32'd15);
    idle_in(1'b1);
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
# br_redirect_ctrl

Execute-stage branch redirect controller, directly downstream of the branch resolution logic. Each cycle it consumes one resolution result: valid, actual taken, prediction-correct flag, actual target, fall-through IP and branch PC. On a misprediction it sequences a one-cycle pipeline flush, then a held redirect to fetch with a valid/ready handshake. For every resolved branch it issues a predictor update pulse and keeps a saturating mispredict counter.

## Interface
Parameters:
- `LINE_BYTES`, default 16: fetch line size in bytes; `redir_ip_p1 = redir_ip + LINE_BYTES`.
- `CNT_W`, default 16: width of the mispredict counter.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high reset.
- `ex_val` input 1: EX-stage instruction valid.
- `br_val` input 1: branch resolution valid, from the branch logic.
- `br_taken` input 1: actual branch outcome.
- `br_correct` input 1: prediction was correct.
- `br_target` input 32: actual taken target (FIP).
- `br_fallthru` input 32: sequential IP after the branch.
- `br_pc` input 32: IP of the branch.
- `fetch_rdy` input 1: fetch accepts the redirect.
- `flush` output 1: one-cycle squash of younger stages.
- `ex_stall` output 1: hold EX while a redirect is pending.
- `redir_val` output 1: redirect request to fetch.
- `redir_ip` output 32: redirect IP.
- `redir_ip_p1` output 32: next fetch line IP.
- `upd_val` output 1: predictor update pulse.
- `upd_taken` output 1: outcome for the update.
- `upd_pc` output 32: branch PC for the update.
- `upd_target` output 32: target for the update.
- `mispred_cnt` output CNT_W: saturating count of mispredictions.

## Operation
- A resolution event is `ex_val & br_val`. Resolution inputs are sampled only in IDLE and ignored in all other states.
- State machine states:
  - IDLE: no redirect in flight.
  - FLUSH: flush cycle.
  - REDIR: redirect request outstanding.
- Transitions:
  - IDLE → FLUSH on a resolution event with `br_correct=0`.
  - FLUSH → REDIR unconditionally.
  - REDIR → IDLE on a clock edge where `redir_val & fetch_rdy`.
  - REDIR holds otherwise.
- On the IDLE→FLUSH edge the block latches:
  - `redir_ip` = `br_target` if `br_taken`, else `br_fallthru`.
  - `redir_ip_p1` = latched `redir_ip + LINE_BYTES`, computed modulo 2^32 (wraps; no carry out).
- Outputs by state:
  - `flush=1` only in FLUSH.
  - `ex_stall=1` in FLUSH and REDIR.
  - `redir_val=1` only in REDIR.
  - `redir_ip` and `redir_ip_p1` stay stable for the whole of REDIR.
- Predictor update:
  - Every resolution event in IDLE, correct or not, registers `upd_val=1` for exactly the next cycle.
  - `upd_taken`, `upd_pc` and `upd_target` carry `br_taken`, `br_pc` and `br_target` from that event.
  - With no event, `upd_val=0` and the data outputs hold their last values.
- `mispred_cnt` increments by 1 on each IDLE→FLUSH edge and saturates at all-ones.
- Reset, including mid-operation, forces on the next edge:
  - state IDLE;
  - all 1-bit outputs 0;
  - `redir_ip`, `redir_ip_p1` and `upd_*` data 0;
  - `mispred_cnt` 0.
  - An abandoned redirect is never re-issued.

## Timing
- Mispredict resolved at edge N:
  - cycle N+1: `flush=1`, `ex_stall=1`, `redir_val=0`.
  - cycle N+2: `redir_val=1`, `ex_stall=1`.
- The handshake completes on the first edge ≥ N+2 with `fetch_rdy=1`. The next cycle is IDLE with `ex_stall=0` and `redir_val=0`. Minimum mispredict penalty is 2 cycles of stall.
- `fetch_rdy` is ignored outside REDIR. `redir_val` never drops before acceptance.
- `upd_val` asserts in cycle N+1 for any resolution at edge N, concurrent with `flush` on a mispredict.
- A resolution event presented during FLUSH or REDIR produces no update, no count and no state change.
- A new mispredict can be accepted in the first IDLE cycle after handshake completion.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Correct prediction:** `ex_val=1`, `br_val=1`, `br_correct=1`, `br_taken=1`, target 0x0000_1200, pc 0x0000_1100.
  - Next cycle: `upd_val=1`, `upd_target=0x1200`.
  - `flush`, `ex_stall` and `redir_val` stay 0; `mispred_cnt=0`.
- **Taken mispredict, fetch ready:** `br_taken=1`, `br_correct=0`, target 0x0000_4000, `fetch_rdy=1`.
  - N+1: `flush=1`.
  - N+2: `redir_val=1`, `redir_ip=0x4000`, `redir_ip_p1=0x4010`.
  - N+3: IDLE; `mispred_cnt=1`.
- **Not-taken mispredict, fetch busy:** `br_taken=0`, `br_correct=0`, fallthru 0x0000_2008, `fetch_rdy=0` for 3 cycles of REDIR.
  - `redir_val` and `ex_stall` held 4 cycles with `redir_ip=0x2008` stable.
  - Released on the edge where `fetch_rdy` rises.
- **Events while busy plus address wrap:** mispredict to target 0xFFFF_FFF8, then further mispredict events during FLUSH and REDIR.
  - `redir_ip_p1=0x0000_0008`.
  - `mispred_cnt` increments once; only one `upd_val` pulse.
- **Reset mid-REDIR:** assert `reset` with `redir_val=1`.
  - Next cycle all outputs 0 and `mispred_cnt=0`.
  - No redirect reappears after `reset` deasserts.
- **Counter saturation:** 65536 back-to-back mispredicts, each acknowledged.
  - `mispred_cnt` reaches 0xFFFF and stays there.
